// File: rtl/leds_pwm_driver_if.sv
// Control/pin bundle between the LED bus interface (master) and the PWM fade driver (slave).
interface leds_pwm_driver_if;
  logic ctrl_en;
  logic ctrl_led0;
  logic ctrl_led1;
  logic ctrl_led2;
  logic ctrl_led3;
  logic led0;
  logic led1;
  logic led2;
  logic led3;
  logic busy;

  modport master (
    output ctrl_en, ctrl_led0, ctrl_led1, ctrl_led2, ctrl_led3,
    input  led0, led1, led2, led3, busy
  );

  modport slave (
    input  ctrl_en, ctrl_led0, ctrl_led1, ctrl_led2, ctrl_led3,
    output led0, led1, led2, led3, busy
  );
endinterface

// File: rtl/leds_pwm_driver.sv
// Four-channel LED driver: per-LED duty ramps one step per prescaler tick toward on/off,
// and a shared free-running PWM counter turns duty into a registered pin waveform.
module leds_pwm_driver #(
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned FADE_DIV       = 1024,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  leds_pwm_driver_if.slave bus_io
);

  localparam int unsigned         NumLeds = 4;
  localparam int unsigned         PreW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PreW-1:0]     PreMax  = PreW'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] DMax    = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {StOff, StRising, StOn, StFalling} led_st_e;

  logic [PreW-1:0]     presc_q, presc_d;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  led_st_e             st_q     [NumLeds];
  led_st_e             st_d     [NumLeds];
  logic [PWM_BITS-1:0] duty_q   [NumLeds];
  logic [PWM_BITS-1:0] duty_d   [NumLeds];
  led_st_e             rise_st  [NumLeds];
  led_st_e             fall_st  [NumLeds];
  logic [PWM_BITS-1:0] rise_dty [NumLeds];
  logic [PWM_BITS-1:0] fall_dty [NumLeds];

  logic [NumLeds-1:0]  ctrl;
  logic [NumLeds-1:0]  up;
  logic [NumLeds-1:0]  lit;
  logic [NumLeds-1:0]  led_q, led_d;
  logic [NumLeds-1:0]  fading;
  logic                busy_q, busy_d;

  assign ctrl = {bus_io.ctrl_led3, bus_io.ctrl_led2, bus_io.ctrl_led1, bus_io.ctrl_led0};

  always_comb begin
    tick    = (presc_q == PreMax);
    presc_d = tick ? '0 : presc_q + 1'b1;
    pwm_d   = pwm_q + 1'b1;
  end

  // Rise/fall candidates are computed for every LED; the FSM picks one by target, so a
  // direction change and a duty step in the same cycle use the new direction.
  always_comb begin
    for (int i = 0; i < NumLeds; i++) begin
      up[i] = bus_io.ctrl_en & ctrl[i];

      rise_st[i]  = StRising;
      rise_dty[i] = duty_q[i];
      if (duty_q[i] == DMax) begin
        rise_st[i] = StOn;
      end else if (tick) begin
        rise_dty[i] = duty_q[i] + 1'b1;
        if (duty_q[i] == DMax - 1'b1) rise_st[i] = StOn;
      end

      fall_st[i]  = StFalling;
      fall_dty[i] = duty_q[i];
      if (duty_q[i] == '0) begin
        fall_st[i] = StOff;
      end else if (tick) begin
        fall_dty[i] = duty_q[i] - 1'b1;
        if (duty_q[i] == PWM_BITS'(1)) fall_st[i] = StOff;
      end

      st_d[i]   = st_q[i];
      duty_d[i] = duty_q[i];
      unique case (st_q[i])
        StOff: begin
          if (up[i]) begin
            st_d[i]   = rise_st[i];
            duty_d[i] = rise_dty[i];
          end
        end
        StOn: begin
          if (!up[i]) begin
            st_d[i]   = fall_st[i];
            duty_d[i] = fall_dty[i];
          end
        end
        StRising, StFalling: begin
          st_d[i]   = up[i] ? rise_st[i]  : fall_st[i];
          duty_d[i] = up[i] ? rise_dty[i] : fall_dty[i];
        end
        default: ;
      endcase

      // Full duty is forced lit so DMAX never shows a one-count dark slot.
      lit[i]    = (duty_q[i] == DMax) || (pwm_q < duty_q[i]);
      led_d[i]  = lit[i] ^ LED_ACTIVE_LOW;
      fading[i] = (st_d[i] == StRising) || (st_d[i] == StFalling);
    end
    busy_d = |fading;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      led_q   <= {NumLeds{LED_ACTIVE_LOW}};
      busy_q  <= 1'b0;
      for (int i = 0; i < NumLeds; i++) begin
        st_q[i]   <= StOff;
        duty_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NumLeds; i++) begin
        st_q[i]   <= st_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign bus_io.led0 = led_q[0];
  assign bus_io.led1 = led_q[1];
  assign bus_io.led2 = led_q[2];
  assign bus_io.led3 = led_q[3];
  assign bus_io.busy = busy_q;

endmodule
